// File: rtl/l2_miss_mem_sequencer_pkg.sv
// Shared definitions for the L2 miss memory sequencer.
// Holds the FSM state encoding, the default line width and the default
// tag/index split of the 26-bit line address.
package l2_miss_mem_sequencer_pkg;

  localparam int L2_LINE_W = 512;
  localparam int L2_TNUM   = 21;
  localparam int L2_INUM   = 26 - L2_TNUM;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_GAP  = 3'd2,
    ST_RD   = 3'd3,
    ST_RESP = 3'd4
  } seq_state_e;

endpackage

// File: rtl/l2_miss_mem_sequencer_req_latch.sv
// l2_miss_req_latch: capture register for one accepted L2 miss.
// Ports:
//   clk, rstn     clock, synchronous active-low reset (clears all fields)
//   load          capture the inputs at this edge
//   miss_tag/miss_index/victim_dirty/victim_tag/victim_data  live L2 fields
//   lat_*         latched copies, stable until the next load
module l2_miss_req_latch #(
  parameter int TNUM   = 21,
  parameter int INUM   = 5,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [TNUM-1:0]   miss_tag,
  input  logic [INUM-1:0]   miss_index,
  input  logic              victim_dirty,
  input  logic [TNUM-1:0]   victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic [TNUM-1:0]   lat_tag,
  output logic [INUM-1:0]   lat_index,
  output logic              lat_dirty,
  output logic [TNUM-1:0]   lat_vtag,
  output logic [LINE_W-1:0] lat_vdata
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_tag   <= '0;
      lat_index <= '0;
      lat_dirty <= 1'b0;
      lat_vtag  <= '0;
      lat_vdata <= '0;
    end else if (load) begin
      lat_tag   <= miss_tag;
      lat_index <= miss_index;
      lat_dirty <= victim_dirty;
      lat_vtag  <= victim_tag;
      lat_vdata <= victim_data;
    end
  end

endmodule

// File: rtl/l2_miss_mem_sequencer.sv
// l2_miss_mem_sequencer: serves one L2 miss at a time against the
// L2-to-BRAM connector. Dirty victims are written back first, followed by
// one idle gap cycle, then the refill read; the refilled line is returned
// with a single-cycle refill_valid_L2 pulse.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   miss_*_L2, victim_*_L2     miss request (level) and victim line from L2
//   refill_valid_L2/data_L2    refill return (pulse + held data)
//   busy_L2                    high whenever not IDLE
//   read/write_L2_MEM, tag/index/write_data_L2_MEM   connector request (level)
//   ready_MEM_L2, read_data_MEM_L2                   connector completion
//   err_L2                     sticky watchdog flag (MEM_TIMEOUT_EN builds)
// Optional feature: define MEM_TIMEOUT_EN to add a per-operation watchdog of
// TIMEOUT cycles that aborts to RESP with zero data and sets err_L2.
// All outputs are registered; the FSM computes next-cycle output values.
module l2_miss_mem_sequencer
  import l2_miss_mem_sequencer_pkg::*;
#(
  parameter int TNUM    = L2_TNUM,
  parameter int INUM    = 26 - TNUM,
  parameter int LINE_W  = L2_LINE_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              miss_req_L2,
  input  logic [TNUM-1:0]   miss_tag_L2,
  input  logic [INUM-1:0]   miss_index_L2,
  input  logic              victim_dirty_L2,
  input  logic [TNUM-1:0]   victim_tag_L2,
  input  logic [LINE_W-1:0] victim_data_L2,
  output logic              refill_valid_L2,
  output logic [LINE_W-1:0] refill_data_L2,
  output logic              busy_L2,
`ifdef MEM_TIMEOUT_EN
  output logic              err_L2,
`endif
  output logic              read_L2_MEM,
  output logic              write_L2_MEM,
  output logic [TNUM-1:0]   tag_L2_MEM,
  output logic [INUM-1:0]   index_L2_MEM,
  output logic [LINE_W-1:0] write_data_L2_MEM,
  input  logic              ready_MEM_L2,
  input  logic [LINE_W-1:0] read_data_MEM_L2
);

  seq_state_e state, state_nxt;

  logic              load;
  logic [TNUM-1:0]   lat_tag, lat_vtag;
  logic [INUM-1:0]   lat_index;
  logic              lat_dirty;
  logic [LINE_W-1:0] lat_vdata;

  logic              read_nxt, write_nxt, rvalid_nxt;
  logic [TNUM-1:0]   tag_nxt;
  logic [INUM-1:0]   index_nxt;
  logic [LINE_W-1:0] wdata_nxt, rdata_nxt;

  l2_miss_req_latch #(
    .TNUM   (TNUM),
    .INUM   (INUM),
    .LINE_W (LINE_W)
  ) u_req_latch (
    .clk          (clk),
    .rstn         (rstn),
    .load         (load),
    .miss_tag     (miss_tag_L2),
    .miss_index   (miss_index_L2),
    .victim_dirty (victim_dirty_L2),
    .victim_tag   (victim_tag_L2),
    .victim_data  (victim_data_L2),
    .lat_tag      (lat_tag),
    .lat_index    (lat_index),
    .lat_dirty    (lat_dirty),
    .lat_vtag     (lat_vtag),
    .lat_vdata    (lat_vdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             expired;

  // Counter holds the number of wait cycles already spent; the TIMEOUT-th
  // wait cycle aborts, so the request level is seen for TIMEOUT cycles.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`else
  // TIMEOUT only has an effect in the watchdog build.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    read_nxt   = read_L2_MEM;
    write_nxt  = write_L2_MEM;
    tag_nxt    = tag_L2_MEM;
    index_nxt  = index_L2_MEM;
    wdata_nxt  = write_data_L2_MEM;
    rvalid_nxt = 1'b0;
    rdata_nxt  = refill_data_L2;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt    = cnt;
    err_nxt    = err_L2;
`endif
    case (state)
      ST_IDLE: begin
        if (miss_req_L2) begin
          load      = 1'b1;
          index_nxt = miss_index_L2;
`ifdef MEM_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
          // Connector outputs come straight from the inputs here because
          // the latch only updates at this same edge.
          if (victim_dirty_L2) begin
            state_nxt = ST_WB;
            write_nxt = 1'b1;
            read_nxt  = 1'b0;
            tag_nxt   = victim_tag_L2;
            wdata_nxt = victim_data_L2;
          end else begin
            state_nxt = ST_RD;
            read_nxt  = 1'b1;
            write_nxt = 1'b0;
            tag_nxt   = miss_tag_L2;
          end
        end
      end
      ST_WB: begin
        // Re-assert from the latch so late L2 input changes cannot leak.
        write_nxt = lat_dirty;
        tag_nxt   = lat_vtag;
        index_nxt = lat_index;
        wdata_nxt = lat_vdata;
        if (ready_MEM_L2) begin
          write_nxt = 1'b0;
          state_nxt = ST_GAP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired) begin
          write_nxt  = 1'b0;
          err_nxt    = 1'b1;
          rvalid_nxt = 1'b1;
          rdata_nxt  = '0;
          state_nxt  = ST_RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        // One dead cycle between write-back and refill on the connector.
        state_nxt = ST_RD;
        read_nxt  = 1'b1;
        write_nxt = 1'b0;
        tag_nxt   = lat_tag;
        index_nxt = lat_index;
`ifdef MEM_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
      end
      ST_RD: begin
        read_nxt  = 1'b1;
        tag_nxt   = lat_tag;
        index_nxt = lat_index;
        if (ready_MEM_L2) begin
          read_nxt   = 1'b0;
          rvalid_nxt = 1'b1;
          rdata_nxt  = read_data_MEM_L2;
          state_nxt  = ST_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired) begin
          read_nxt   = 1'b0;
          err_nxt    = 1'b1;
          rvalid_nxt = 1'b1;
          rdata_nxt  = '0;
          state_nxt  = ST_RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state             <= ST_IDLE;
      read_L2_MEM       <= 1'b0;
      write_L2_MEM      <= 1'b0;
      tag_L2_MEM        <= '0;
      index_L2_MEM      <= '0;
      write_data_L2_MEM <= '0;
      refill_valid_L2   <= 1'b0;
      refill_data_L2    <= '0;
      busy_L2           <= 1'b0;
    end else begin
      state             <= state_nxt;
      read_L2_MEM       <= read_nxt;
      write_L2_MEM      <= write_nxt;
      tag_L2_MEM        <= tag_nxt;
      index_L2_MEM      <= index_nxt;
      write_data_L2_MEM <= wdata_nxt;
      refill_valid_L2   <= rvalid_nxt;
      refill_data_L2    <= rdata_nxt;
      busy_L2           <= (state_nxt != ST_IDLE);
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      err_L2 <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      err_L2 <= err_nxt;
    end
  end
`endif

endmodule
